// File: rtl/matmul_host_ctrl.sv
// matmul_host_ctrl: streams input/weight words into SRAM, kicks the compute core, then drains the result SRAM to a stream
module matmul_host_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  in_count,
    input  logic [CNT_WIDTH-1:0]  wt_count,
    input  logic [CNT_WIDTH-1:0]  res_count,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  sram_input_write_enable,
    output logic [ADDR_WIDTH-1:0] sram_input_write_address,
    output logic [DATA_WIDTH-1:0] sram_input_write_data,
    output logic                  sram_weight_write_enable,
    output logic [ADDR_WIDTH-1:0] sram_weight_write_address,
    output logic [DATA_WIDTH-1:0] sram_weight_write_data,
    output logic [ADDR_WIDTH-1:0] sram_result_read_address,
    input  logic [DATA_WIDTH-1:0] sram_result_read_data,
    output logic                  dut_valid,
    input  logic                  dut_ready,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, LOAD_IN, LOAD_WT, KICK, WAIT_DONE, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_WIDTH-1:0]  in_cnt, wt_cnt, res_cnt, wr_idx, wr_nx, rd_cnt, rd_nx, tx_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] fifo [2];
    logic [1:0]            occ, occ_after;
    logic                  head, tail, in_flight, dut_valid_r;
    logic                  wr_fire, wr_last, pop, issue, load_in, load_wt;

    assign load_in   = state == LOAD_IN;
    assign load_wt   = state == LOAD_WT;
    assign s_ready   = load_in || load_wt;
    assign wr_fire   = s_valid && s_ready;
    assign wr_nx     = wr_idx + CNT_WIDTH'(1);
    assign wr_last   = wr_nx == (load_wt ? wt_cnt : in_cnt);
    assign sram_input_write_enable   = load_in && s_valid;
    assign sram_input_write_address  = load_in ? wr_idx[ADDR_WIDTH-1:0] : '0;
    assign sram_input_write_data     = load_in ? s_data : '0;
    assign sram_weight_write_enable  = load_wt && s_valid;
    assign sram_weight_write_address = load_wt ? wr_idx[ADDR_WIDTH-1:0] : '0;
    assign sram_weight_write_data    = load_wt ? s_data : '0;
    assign sram_result_read_address  = rd_addr;
    assign dut_valid = dut_valid_r;
    assign m_valid   = occ != 2'd0;
    assign m_data    = m_valid ? fifo[head] : '0;
    assign m_last    = m_valid && (tx_cnt + CNT_WIDTH'(1)) == res_cnt;
    assign pop       = m_valid && m_ready;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    // Occupancy after this cycle's pop and the arriving read; issuing against it keeps 1 word/cycle without overflow
    assign occ_after = occ - {1'b0, pop} + {1'b0, in_flight};
    assign rd_nx     = rd_cnt + CNT_WIDTH'(1);
    assign issue     = state == DRAIN && rd_cnt != res_cnt && occ_after < 2'd2;

    // Next-state selection; zero-length phases are skipped on the same transition
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start) state_nx = in_count != '0 ? LOAD_IN : wt_count != '0 ? LOAD_WT : KICK;
            LOAD_IN:   if (wr_fire && wr_last) state_nx = wt_cnt != '0 ? LOAD_WT : KICK;
            LOAD_WT:   if (wr_fire && wr_last) state_nx = KICK;
            KICK:      if (!dut_ready) state_nx = WAIT_DONE;
            WAIT_DONE: if (dut_ready) state_nx = res_cnt != '0 ? DRAIN : DONE;
            DRAIN:     if (pop && m_last) state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // Latched counts, load index, core request, result read pipeline and output FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt      <= '0;
            wt_cnt      <= '0;
            res_cnt     <= '0;
            wr_idx      <= '0;
            rd_cnt      <= '0;
            rd_addr     <= '0;
            tx_cnt      <= '0;
            dut_valid_r <= 1'b0;
            in_flight   <= 1'b0;
            occ         <= '0;
            head        <= 1'b0;
            tail        <= 1'b0;
            fifo[0]     <= '0;
            fifo[1]     <= '0;
        end else begin
            if (state == IDLE && start) begin
                in_cnt  <= in_count;
                wt_cnt  <= wt_count;
                res_cnt <= res_count;
                wr_idx  <= '0;
            end
            if (wr_fire) wr_idx <= wr_last ? '0 : wr_nx;
            dut_valid_r <= state_nx == KICK;
            in_flight   <= issue;
            if (issue) begin
                rd_cnt <= rd_nx;
                if (rd_nx != res_cnt) rd_addr <= rd_addr + ADDR_WIDTH'(1);
            end
            if (in_flight) begin
                fifo[tail] <= sram_result_read_data;
                tail       <= ~tail;
            end
            if (pop) begin
                head   <= ~head;
                tx_cnt <= tx_cnt + CNT_WIDTH'(1);
            end
            occ <= occ_after;
            if (state == DONE) begin
                rd_cnt  <= '0;
                rd_addr <= '0;
                tx_cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_matmul_host_ctrl.sv
// tb_matmul_host_ctrl: table-driven runs with write/result scoreboards, core and result-SRAM models
module tb_matmul_host_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, s_valid, s_ready, m_valid, m_ready, m_last, busy, done;
    logic [15:0] in_count, wt_count, res_count;
    logic [31:0] s_data, m_data, sram_result_read_data;
    logic        sram_input_write_enable, sram_weight_write_enable, dut_valid, dut_ready;
    logic [11:0] sram_input_write_address, sram_weight_write_address, sram_result_read_address;
    logic [31:0] sram_input_write_data, sram_weight_write_data;

    matmul_host_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .in_count(in_count), .wt_count(wt_count), .res_count(res_count),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .sram_input_write_enable(sram_input_write_enable),
        .sram_input_write_address(sram_input_write_address),
        .sram_input_write_data(sram_input_write_data),
        .sram_weight_write_enable(sram_weight_write_enable),
        .sram_weight_write_address(sram_weight_write_address),
        .sram_weight_write_data(sram_weight_write_data),
        .sram_result_read_address(sram_result_read_address),
        .sram_result_read_data(sram_result_read_data),
        .dut_valid(dut_valid), .dut_ready(dut_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Core model: ready drops two edges after valid is seen, returns 20 cycles later
    logic core_rdy;
    int   core_t;
    assign dut_ready = core_rdy;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rdy <= 1'b1;
            core_t   <= 0;
        end else if (core_t == 0) begin
            if (dut_valid && core_rdy) core_t <= 1;
        end else begin
            core_t <= core_t + 1;
            if (core_t == 1) core_rdy <= 1'b0;
            if (core_t == 21) begin
                core_rdy <= 1'b1;
                core_t   <= 0;
            end
        end
    end

    // Result SRAM model with one cycle read latency
    logic [31:0] res_mem [16];
    always @(posedge clk) sram_result_read_data <= res_mem[sram_result_read_address[3:0]];

    typedef struct {
        int          ic, wc, rc;
        logic [7:0]  spat, mpat;
        logic [31:0] wbase, rbase;
        bit          poke;
        bit          exp_sready, exp_kick_now;
        int          exp_words;
        bit          consec;
    } vec_t;
    typedef struct {
        bit          wt;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    int          total = 0, bad = 0;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " s_ready"}, s_ready, 0);
        chk({tag, " in_we"}, sram_input_write_enable, 0);
        chk({tag, " in_addr"}, sram_input_write_address, 0);
        chk({tag, " in_data"}, sram_input_write_data, 0);
        chk({tag, " wt_we"}, sram_weight_write_enable, 0);
        chk({tag, " wt_addr"}, sram_weight_write_address, 0);
        chk({tag, " wt_data"}, sram_weight_write_data, 0);
        chk({tag, " rd_addr"}, sram_result_read_address, 0);
        chk({tag, " dut_valid"}, dut_valid, 0);
        chk({tag, " m_valid"}, m_valid, 0);
        chk({tag, " m_data"}, m_data, 0);
        chk({tag, " m_last"}, m_last, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
    endtask

    task automatic run_vec(input vec_t v, input int abort);
        logic [31:0] words[$];
        logic [31:0] prev_md, exp_d;
        wr_t         e;
        int          src, nf, first_f, last_f, done_cnt, done_cyc, kicks, mv_cnt;
        bit          prev_mv, prev_mr, prev_dv, prev_rdy, s_fire, m_fire, we_any, fin;
        wq.delete();
        rq.delete();
        for (int k = 0; k < v.ic + v.wc; k++) words.push_back(v.wbase + k);
        for (int k = 0; k < v.ic; k++) begin
            e = '{1'b0, k, words[k]};
            wq.push_back(e);
        end
        for (int k = 0; k < v.wc; k++) begin
            e = '{1'b1, k, words[v.ic + k]};
            wq.push_back(e);
        end
        for (int k = 0; k < 16; k++) res_mem[k] = v.rbase + k;
        for (int k = 0; k < v.rc; k++) rq.push_back(v.rbase + k);
        @(negedge clk);
        start     = 1'b1;
        in_count  = 16'(v.ic);
        wt_count  = 16'(v.wc);
        res_count = 16'(v.rc);
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        #1;
        chk("busy before start", busy, 0);
        @(posedge clk);
        src = 0; nf = 0; first_f = 0; last_f = 0; done_cnt = 0; done_cyc = 0; kicks = 0; mv_cnt = 0;
        prev_mv = 0; prev_mr = 0; prev_dv = 0; prev_rdy = 1; prev_md = '0; fin = 0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (abort > 0 && nf == abort) return;
            @(negedge clk);
            start = v.poke && busy && !done;
            if (start) begin
                in_count  = 16'd1;
                wt_count  = 16'd1;
                res_count = 16'd1;
            end
            s_valid = v.spat[cyc % 8] && src < v.ic + v.wc;
            s_data  = '0;
            if (s_valid) s_data = words[src];
            m_ready = v.mpat[cyc % 8];
            #1;
            if (cyc == 0) begin
                chk("busy after start", busy, 1);
                chk("s_ready after start", s_ready, v.exp_sready);
                chk("dut_valid after start", dut_valid, v.exp_kick_now);
            end
            s_fire = s_valid && s_ready;
            m_fire = m_valid && m_ready;
            we_any = sram_input_write_enable || sram_weight_write_enable;
            if (we_any || s_fire) chk("write iff handshake", we_any, s_fire);
            if (we_any) begin
                chk("single write target", sram_input_write_enable && sram_weight_write_enable, 0);
                if (wq.size() == 0) fail("unexpected write");
                else begin
                    e = wq.pop_front();
                    chk("write target", sram_weight_write_enable, e.wt);
                    chk("write addr", e.wt ? sram_weight_write_address : sram_input_write_address, e.addr);
                    chk("write data", e.wt ? sram_weight_write_data : sram_input_write_data, e.data);
                end
            end
            if (m_valid) begin
                mv_cnt++;
                chk("read ahead", int'(sram_result_read_address) - nf <= 2, 1);
            end
            if (prev_mv && !prev_mr) begin
                chk("m_valid held", m_valid, 1);
                chk("m_data stable", m_data, prev_md);
            end
            if (m_fire) begin
                if (rq.size() == 0) fail("extra result word");
                else begin
                    exp_d = rq.pop_front();
                    chk("m_data", m_data, exp_d);
                    chk("m_last", m_last, rq.size() == 0);
                end
                if (nf == 0) first_f = cyc;
                last_f = cyc;
                nf++;
            end
            if (prev_dv && !prev_rdy) chk("dut_valid drops after ack", dut_valid, 0);
            if (prev_dv && !dut_valid) chk("dut_valid held until ack", prev_rdy, 0);
            if (dut_valid && !prev_dv) kicks++;
            if (done_cnt > 0 && !done) begin
                chk("idle after done", busy, 0);
                fin = 1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_mv  = m_valid;
            prev_mr  = m_ready;
            prev_md  = m_data;
            prev_dv  = dut_valid;
            prev_rdy = dut_ready;
            @(posedge clk);
            if (s_fire) src++;
        end
        start = 1'b0;
        if (!fin) fail("run timeout");
        chk("done pulses", done_cnt, 1);
        chk("results delivered", nf, v.exp_words);
        chk("stream words consumed", src, v.ic + v.wc);
        chk("pending writes", wq.size(), 0);
        chk("core kicks", kicks, 1);
        if (v.rc == 0) chk("m_valid cycles", mv_cnt, 0);
        if (v.consec && nf > 0) begin
            chk("burst span", last_f - first_f, v.rc - 1);
            chk("done after last", done_cyc - last_f, 1);
        end
    endtask

    initial begin
        vec_t rv;
        //          ic wc rc  spat   mpat   wbase      rbase     poke sready kick words consec
        vecs[0] = '{5, 5, 4, 8'hFF, 8'hFF, 32'h100, 32'hA0, 1'b0, 1'b1, 1'b0, 4, 1'b1};
        vecs[1] = '{3, 4, 3, 8'h55, 8'hFF, 32'h200, 32'hB0, 1'b0, 1'b1, 1'b0, 3, 1'b0};
        vecs[2] = '{2, 2, 6, 8'hFF, 8'hF4, 32'h300, 32'hC0, 1'b0, 1'b1, 1'b0, 6, 1'b0};
        vecs[3] = '{3, 0, 2, 8'hFF, 8'hFF, 32'h400, 32'hD0, 1'b0, 1'b1, 1'b0, 2, 1'b1};
        vecs[4] = '{2, 2, 0, 8'hFF, 8'hFF, 32'h500, 32'hE0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[5] = '{0, 0, 3, 8'hFF, 8'hFF, 32'h600, 32'h10, 1'b0, 1'b0, 1'b1, 3, 1'b1};
        vecs[6] = '{0, 3, 2, 8'hFF, 8'hFF, 32'h650, 32'h20, 1'b0, 1'b1, 1'b0, 2, 1'b0};
        vecs[7] = '{4, 4, 3, 8'h77, 8'hDB, 32'h700, 32'hF0, 1'b1, 1'b1, 1'b0, 3, 1'b0};
        reset = 1'b1; start = 1'b0; in_count = '0; wt_count = '0; res_count = '0;
        s_valid = 1'b0; s_data = 32'h5A5A_5A5A; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_zero("por");
        reset = 1'b0;
        for (int i = 0; i < 8; i++) run_vec(vecs[i], 0);
        rv = '{2, 2, 6, 8'hFF, 8'hFF, 32'h800, 32'h30, 1'b0, 1'b1, 1'b0, 6, 1'b0};
        run_vec(rv, 2);
        @(negedge clk);
        s_data = 32'h5A5A_5A5A;
        reset  = 1'b1;
        #1;
        chk_zero("mid-drain reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[0], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
